// File: rtl/prince_sbox_compress_d2.sv
// PRINCE S-box compression stage, 3-share masked: ANF compression of per-share
// monomial vectors, fresh-randomness refresh, and a two-register output pipeline.
module prince_sbox_compress_d2 #(
  parameter logic [55:0] COEF = 56'h00_2000_4000_8001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] mono_s0,
  input  logic [13:0] mono_s1,
  input  logic [13:0] mono_s2,
  input  logic [7:0]  rnd,
  input  logic        rnd_valid,
  output logic        rnd_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_s0,
  output logic [3:0]  out_s1,
  output logic [3:0]  out_s2,
  output logic [15:0] out_cnt
);

  function automatic logic [3:0] compress(input logic [13:0] m);
    logic [3:0] y;
    y = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      y[j] = ^(COEF[14*j +: 14] & m);
    end
    return y;
  endfunction

  logic       a_valid, b_valid;
  logic [3:0] a_s0, a_s1, a_s2;
  logic [3:0] b_s0, b_s1, b_s2;
  logic [3:0] z0, z1, z2;
  logic [3:0] r0, r1;
  logic       a_free, b_free, accept;

  assign r0 = rnd[3:0];
  assign r1 = rnd[7:4];

  // Each share is refreshed on its own; the combined XOR is never formed.
  always_comb begin
    z0 = compress(mono_s0) ^ r0;
    z1 = compress(mono_s1) ^ r1;
    z2 = compress(mono_s2) ^ r0 ^ r1;
  end

  assign b_free   = !b_valid | out_ready;
  assign a_free   = !a_valid | b_free;
  // rst gating keeps the handshake quiet while reset is held.
  assign in_ready = a_free & rnd_valid & !rst;
  assign accept   = in_valid & in_ready;
  assign rnd_ack  = accept;

  assign out_valid = b_valid;
  assign out_s0    = b_s0;
  assign out_s1    = b_s1;
  assign out_s2    = b_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_s0    <= '0;
      a_s1    <= '0;
      a_s2    <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_s0    <= z0;
      a_s1    <= z1;
      a_s2    <= z2;
    end else if (a_free) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_s0    <= '0;
      b_s1    <= '0;
      b_s2    <= '0;
    end else if (a_valid && b_free) begin
      b_valid <= 1'b1;
      b_s0    <= a_s0;
      b_s1    <= a_s1;
      b_s2    <= a_s2;
    end else if (b_free) begin
      b_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
    end else if (b_valid && out_ready) begin
      out_cnt <= out_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_prince_sbox_compress_d2.sv
// Self-checking bench for prince_sbox_compress_d2: fixed vectors, backpressure,
// randomness starvation, reset flush and a random stream against a queue model.
module tb_prince_sbox_compress_d2;

  localparam logic [55:0] COEF1 = 56'h00_2000_4000_8001;
  localparam logic [55:0] COEF2 = 56'hA5C3_96F0_1E2D_7B;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, rnd_valid, out_ready;
  logic [13:0] mono_s0, mono_s1, mono_s2;
  logic [7:0]  rnd;
  logic        in_ready, rnd_ack, out_valid;
  logic [3:0]  out_s0, out_s1, out_s2;
  logic [15:0] out_cnt;
  logic        o2_in_ready, o2_rnd_ack, o2_valid;
  logic [3:0]  o2_s0, o2_s1, o2_s2;
  logic [15:0] o2_cnt;

  prince_sbox_compress_d2 #(.COEF(COEF1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mono_s0(mono_s0), .mono_s1(mono_s1), .mono_s2(mono_s2),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ack(rnd_ack),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2), .out_cnt(out_cnt)
  );

  prince_sbox_compress_d2 #(.COEF(COEF2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o2_in_ready),
    .mono_s0(mono_s0), .mono_s1(mono_s1), .mono_s2(mono_s2),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ack(o2_rnd_ack),
    .out_valid(o2_valid), .out_ready(out_ready),
    .out_s0(o2_s0), .out_s1(o2_s1), .out_s2(o2_s2), .out_cnt(o2_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] e0, e1, e2;
    logic [3:0] f0, f1, f2;
    logic [3:0] yx;
    int         t;
  } item_t;

  typedef struct {
    logic [13:0] m0, m1, m2;
    logic [7:0]  r;
    logic [3:0]  e0, e1, e2;
  } vec_t;

  item_t       q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          hs_cnt = 0;
  logic [15:0] cnt_model = '0;
  logic        stalled = 1'b0;
  logic [3:0]  held0, held1, held2;
  logic [3:0]  hs0, hs1, hs2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Parity of selected monomials, bit by bit, by counting.
  function automatic logic [3:0] ref_compress(input logic [55:0] coef, input logic [13:0] m);
    logic [3:0] y;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      int n;
      n = 0;
      for (int k = 0; k < 14; k++)
        if (coef[14*j+k] && m[k]) n++;
      y[j] = (n % 2 == 1);
    end
    return y;
  endfunction

  task automatic step(input logic iv, input logic [13:0] m0, input logic [13:0] m1,
                      input logic [13:0] m2, input logic [7:0] r, input logic rv,
                      input logic ordy);
    logic  er, eov;
    item_t it;
    logic [3:0] y0, y1, y2, r0, r1;
    in_valid = iv; mono_s0 = m0; mono_s1 = m1; mono_s2 = m2;
    rnd = r; rnd_valid = rv; out_ready = ordy;
    #1;
    er  = rv & ((q.size() < 2) | ordy);
    eov = (q.size() > 0) && (cyc >= q[0].t + 2);
    chk("in_ready", in_ready, er);
    chk("rnd_ack", rnd_ack, iv & er);
    chk("out_valid", out_valid, eov);
    chk("out_valid_coef2", o2_valid, eov);
    chk("out_cnt", out_cnt, cnt_model);
    if (stalled && eov) begin
      chk("hold_s0", out_s0, held0);
      chk("hold_s1", out_s1, held1);
      chk("hold_s2", out_s2, held2);
    end
    if (eov && ordy) begin
      it = q.pop_front();
      chk("out_s0", out_s0, it.e0);
      chk("out_s1", out_s1, it.e1);
      chk("out_s2", out_s2, it.e2);
      chk("share_xor", out_s0 ^ out_s1 ^ out_s2, it.yx);
      chk("coef2_s0", o2_s0, it.f0);
      chk("coef2_s1", o2_s1, it.f1);
      chk("coef2_s2", o2_s2, it.f2);
      hs0 = out_s0; hs1 = out_s1; hs2 = out_s2;
      cnt_model++;
      hs_cnt++;
    end
    if (iv && er) begin
      r0 = r[3:0]; r1 = r[7:4];
      y0 = ref_compress(COEF1, m0); y1 = ref_compress(COEF1, m1); y2 = ref_compress(COEF1, m2);
      it.e0 = y0 ^ r0; it.e1 = y1 ^ r1; it.e2 = y2 ^ r0 ^ r1;
      it.yx = y0 ^ y1 ^ y2;
      y0 = ref_compress(COEF2, m0); y1 = ref_compress(COEF2, m1); y2 = ref_compress(COEF2, m2);
      it.f0 = y0 ^ r0; it.f1 = y1 ^ r1; it.f2 = y2 ^ r0 ^ r1;
      it.t = cyc;
      q.push_back(it);
      acc_cnt++;
    end
    stalled = eov & !ordy;
    held0 = out_s0; held1 = out_s1; held2 = out_s2;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, '0, '0, 1'b1, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rnd_ack", rnd_ack, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_s0", out_s0, 0);
    chk("rst_coef2_valid", o2_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    cnt_model = '0;
    stalled = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int   a0, h0;
    rst = 1'b1; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
    mono_s0 = '0; mono_s1 = '0; mono_s2 = '0; rnd = '0;

    vecs[0] = '{14'h0005, 14'h0000, 14'h0000, 8'h00, 4'h5, 4'h0, 4'h0};
    vecs[1] = '{14'h0005, 14'h0000, 14'h0000, 8'h03, 4'h6, 4'h0, 4'h3};
    vecs[2] = '{14'h000A, 14'h0003, 14'h000C, 8'h00, 4'hA, 4'h3, 4'hC};
    vecs[3] = '{14'h3FF0, 14'h3FF0, 14'h3FF0, 8'h00, 4'h0, 4'h0, 4'h0};
    vecs[4] = '{14'h0001, 14'h0002, 14'h0004, 8'hA5, 4'h4, 4'h8, 4'hB};
    vecs[5] = '{14'h3FFF, 14'h000F, 14'h0000, 8'h1E, 4'h1, 4'hE, 4'hF};

    do_reset();

    // Fixed vectors: accept, then the result appears two cycles later.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].m0, vecs[i].m1, vecs[i].m2, vecs[i].r, 1'b1, 1'b1);
      h0 = hs_cnt;
      idle(1'b1);
      idle(1'b1);
      chk("vec_handshake", hs_cnt - h0, 1);
      chk("vec_s0", hs0, vecs[i].e0);
      chk("vec_s1", hs1, vecs[i].e1);
      chk("vec_s2", hs2, vecs[i].e2);
    end
    chk("vec_out_cnt", out_cnt, 6);

    // Backpressure: only two items fit, then a simultaneous pop+accept.
    do_reset();
    a0 = acc_cnt;
    step(1'b1, 14'h0001, '0, '0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 14'h0002, '0, '0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 14'h0004, '0, '0, 8'h00, 1'b1, 1'b0);
    chk("bp_accepted", acc_cnt - a0, 2);
    for (int i = 0; i < 5 && acc_cnt - a0 < 3; i++)
      step(1'b1, 14'h0004, '0, '0, 8'h00, 1'b1, 1'b1);
    chk("bp_third_accepted", acc_cnt - a0, 3);
    drain();
    chk("bp_out_cnt", out_cnt, 3);

    // No randomness, no accept; accept in the cycle rnd_valid rises.
    a0 = acc_cnt;
    for (int i = 0; i < 3; i++) step(1'b1, 14'h0009, '0, '0, 8'h5A, 1'b0, 1'b1);
    chk("norand_no_accept", acc_cnt - a0, 0);
    step(1'b1, 14'h0009, '0, '0, 8'h5A, 1'b1, 1'b1);
    chk("rand_rise_accept", acc_cnt - a0, 1);
    drain();

    // Reset with two items in flight discards both.
    do_reset();
    step(1'b1, 14'h0003, '0, '0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 14'h0006, '0, '0, 8'h00, 1'b1, 1'b0);
    idle(1'b0);
    do_reset();
    h0 = hs_cnt;
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("rst_no_stale", hs_cnt - h0, 0);
    step(1'b1, 14'h000F, '0, '0, 8'h00, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("rst_first_out", hs_cnt - h0, 1);
    chk("rst_first_s0", hs0, 4'hF);

    // Random stream of 100 items with random backpressure.
    do_reset();
    a0 = acc_cnt;
    for (int c = 0; c < 3000 && acc_cnt - a0 < 100; c++) begin
      logic [13:0] m0, m1, m2;
      m0 = 14'($urandom()); m1 = 14'($urandom()); m2 = 14'($urandom());
      step($urandom_range(0, 3) != 0, m0, m1, m2, 8'($urandom()),
           $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
    end
    chk("rand_accepted", acc_cnt - a0, 100);
    drain();
    chk("rand_out_cnt", out_cnt, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
